// File: rtl/tt_disp_pkg.sv
// Shared types and 7-segment encoding for the MM:SS display scanner.
package tt_disp_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } mmss_t;

  // Segment order is {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7_encode(input bcd_t value);
    case (value)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Single BCD digit counting 0..MAX; adds 0..2 per cycle and flags wrap-around as carry.
module bcd_mod_counter
  import tt_disp_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] inc_i,
  input  logic       clr_i,
  output bcd_t       q_o,
  output logic       carry_o
);

  bcd_t       cnt_q;
  bcd_t       cnt_d;
  logic [4:0] sum;

  // Step never exceeds 2 and the digit stays <= MAX, so one subtraction wraps it
  always_comb begin
    sum     = {1'b0, cnt_q} + {3'b000, inc_i};
    carry_o = 1'b0;
    cnt_d   = sum[3:0];
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum > 5'(MAX)) begin
      carry_o = 1'b1;
      cnt_d   = 4'(sum - 5'(MAX + 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/tt_mmss_display_scanner.sv
// BCD MM:SS clock driven by a 1 Hz tick, shown as a time-multiplexed 7-segment digit stream.
module tt_mmss_display_scanner
  import tt_disp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 256,
  parameter bit          SEG_ACT_LOW  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       run_i,
  input  logic       adv_min_i,
  input  logic       clr_sec_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [1:0] digit_sel_o
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LAST_SHOW  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  localparam logic [6:0] SEG_RST = SEG_ACT_LOW ? ~SEG_0 : SEG_0;
  localparam logic       DP_RST  = !SEG_ACT_LOW;

  mmss_t      timeNow;
  logic       secInc;
  logic       s0Carry;
  logic       s1Carry;
  logic       m0Carry;
  logic       unusedHourCarry;
  logic [1:0] minStep;

  assign secInc  = tick_i & run_i;
  assign minStep = {1'b0, adv_min_i} + {1'b0, s1Carry};

  bcd_mod_counter #(.MAX(9)) u_sec_units (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   ({1'b0, secInc}),
    .clr_i   (clr_sec_i),
    .q_o     (timeNow.s0),
    .carry_o (s0Carry)
  );

  bcd_mod_counter #(.MAX(5)) u_sec_tens (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   ({1'b0, s0Carry}),
    .clr_i   (clr_sec_i),
    .q_o     (timeNow.s1),
    .carry_o (s1Carry)
  );

  bcd_mod_counter #(.MAX(9)) u_min_units (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (minStep),
    .clr_i   (1'b0),
    .q_o     (timeNow.m0),
    .carry_o (m0Carry)
  );

  // No hours: the wrap out of 59 minutes is simply dropped
  bcd_mod_counter #(.MAX(5)) u_min_tens (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   ({1'b0, m0Carry}),
    .clr_i   (1'b0),
    .q_o     (timeNow.m1),
    .carry_o (unusedHourCarry)
  );

  logic [0:0]       scanState_q;
  logic [0:0]       scanState_d;
  logic [CNT_W-1:0] dwellCnt_q;
  logic [CNT_W-1:0] dwellCnt_d;
  digit_idx_t       digitSel_q;
  digit_idx_t       digitSel_d;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;
  logic             dp_q;
  logic             dp_d;
  bcd_t             shownDigit;
  logic [6:0]       segRaw;
  logic             dpRaw;

  always_comb begin
    scanState_d = scanState_q;
    dwellCnt_d  = dwellCnt_q + 1'b1;
    digitSel_d  = digitSel_q;
    case (scanState_q)
      ST_SHOW: begin
        if (dwellCnt_q == LAST_SHOW) begin
          scanState_d = ST_BLANK;
          dwellCnt_d  = '0;
        end
      end
      ST_BLANK: begin
        if (dwellCnt_q == LAST_BLANK) begin
          scanState_d = ST_SHOW;
          dwellCnt_d  = '0;
          digitSel_d  = digitSel_q + 2'd1;
        end
      end
      default: begin
        scanState_d = ST_SHOW;
        dwellCnt_d  = '0;
      end
    endcase
  end

  // Output regs follow the scan state they describe, so each SHOW/BLANK lasts exactly its count
  always_comb begin
    case (digitSel_d)
      2'd0:    shownDigit = timeNow.m1;
      2'd1:    shownDigit = timeNow.m0;
      2'd2:    shownDigit = timeNow.s1;
      default: shownDigit = timeNow.s0;
    endcase
    segRaw = SEG_BLANK;
    dpRaw  = 1'b0;
    if (scanState_d == ST_SHOW) begin
      segRaw = seg7_encode(shownDigit);
      dpRaw  = (digitSel_d == 2'd0);
    end
    seg_d = SEG_ACT_LOW ? ~segRaw : segRaw;
    dp_d  = SEG_ACT_LOW ? ~dpRaw : dpRaw;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scanState_q <= ST_SHOW;
      dwellCnt_q  <= '0;
      digitSel_q  <= '0;
      seg_q       <= SEG_RST;
      dp_q        <= DP_RST;
    end else begin
      scanState_q <= scanState_d;
      dwellCnt_q  <= dwellCnt_d;
      digitSel_q  <= digitSel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign digit_sel_o = digitSel_q;

endmodule

// File: tb/tb_tt_mmss_display_scanner.sv
// Self-checking bench: seconds-count time model plus frame-position scan model, compared every cycle.
module tb_tt_mmss_display_scanner;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       tick   = 1'b0;
  logic       run    = 1'b0;
  logic       advMin = 1'b0;
  logic       clrSec = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digitSel;

  int checks   = 0;
  int failures = 0;

  int modelTime  = 0;
  int shownTime  = 0;
  int scanCycle  = 0;
  bit modelValid = 1'b0;

  logic [6:0] segTable [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  tt_mmss_display_scanner #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK),
    .SEG_ACT_LOW  (1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .run_i       (run),
    .adv_min_i   (advMin),
    .clr_sec_i   (clrSec),
    .seg_o       (seg),
    .dp_o        (dp),
    .digit_sel_o (digitSel)
  );

  always #5 clk = ~clk;

  // Time kept as plain seconds since 00:00
  function automatic int nextTime(int t, bit tk, bit rn, bit adv, bit clr);
    int s = t % 60;
    int m = t / 60;
    int carry = 0;
    if (clr) begin
      s = 0;
    end else if (tk && rn) begin
      s = s + 1;
      if (s == 60) begin
        s = 0;
        carry = 1;
      end
    end
    m = (m + int'(adv) + carry) % 60;
    return m * 60 + s;
  endfunction

  function automatic int digitOf(int t, int idx);
    case (idx)
      0:       return t / 600;
      1:       return (t / 60) % 10;
      2:       return (t % 60) / 10;
      default: return t % 10;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(bit tk, bit adv, bit clr);
    @(negedge clk);
    tick   = tk;
    advMin = adv;
    clrSec = clr;
    @(negedge clk);
    tick   = 1'b0;
    advMin = 1'b0;
    clrSec = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b0;
    advMin = 1'b0;
    clrSec = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model advances on each edge; outputs are compared 1 time unit later
  always @(posedge clk) begin
    if (rst) begin
      modelTime  = 0;
      shownTime  = 0;
      scanCycle  = 0;
      modelValid = 1'b1;
    end else begin
      shownTime = modelTime;
      modelTime = nextTime(modelTime, tick, run, advMin, clrSec);
      scanCycle = scanCycle + 1;
    end
    #1;
    if (modelValid) begin
      int p;
      int slot;
      bit show;
      logic [6:0] expSeg;
      p      = scanCycle % FRAME;
      slot   = p / SLOT;
      show   = (p % SLOT) < DWELL;
      expSeg = show ? segTable[digitOf(shownTime, slot)] : 7'h00;
      checkOutput("scanSeg", 32'(seg), 32'(expSeg));
      checkOutput("scanDp", 32'(dp), 32'(show && (slot == 0)));
      checkOutput("scanSel", 32'(digitSel), 32'(slot));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;

    // Reset state and one idle frame with hand-computed positions
    doReset();
    checkOutput("rstSeg", 32'(seg), 32'h3F);
    checkOutput("rstDp", 32'(dp), 32'd1);
    checkOutput("rstSel", 32'(digitSel), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("blank0Seg", 32'(seg), 32'h00);
    checkOutput("blank0Dp", 32'(dp), 32'd0);
    checkOutput("blank0Sel", 32'(digitSel), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("show1Seg", 32'(seg), 32'h3F);
    checkOutput("show1Dp", 32'(dp), 32'd0);
    checkOutput("show1Sel", 32'(digitSel), 32'd1);
    repeat (17) @(negedge clk);
    checkOutput("blank3Seg", 32'(seg), 32'h00);
    checkOutput("blank3Sel", 32'(digitSel), 32'd3);
    @(negedge clk);
    checkOutput("wrapSel", 32'(digitSel), 32'd0);
    checkOutput("wrapDp", 32'(dp), 32'd1);

    // 61 ticks from 00:00
    run = 1'b1;
    repeat (60) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t60", 32'(modelTime), 32'd60);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t61", 32'(modelTime), 32'd61);
    repeat (FRAME) @(negedge clk);

    // Preload 59:59 and roll over
    doReset();
    repeat (59) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (59) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5959", 32'(modelTime), 32'd3599);
    repeat (FRAME) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap0000", 32'(modelTime), 32'd0);
    repeat (FRAME) @(negedge clk);

    // Frozen time still obeys set inputs
    run = 1'b0;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("frozen", 32'(modelTime), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("frozenAdv", 32'(modelTime), 32'd60);
    run = 1'b1;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    run = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("frozenClr", 32'(modelTime), 32'd60);
    repeat (FRAME) @(negedge clk);

    // Double minute increment and clear-beats-tick
    doReset();
    run = 1'b1;
    repeat (59) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t0200", 32'(modelTime), 32'd120);
    repeat (FRAME) @(negedge clk);
    doReset();
    repeat (9) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clrTick", 32'(modelTime), 32'd0);
    repeat (7) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("clrAdv", 32'(modelTime), 32'd60);
    repeat (FRAME) @(negedge clk);

    // Randomised inputs including occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      tick   = 1'($urandom_range(0, 1));
      run    = ($urandom_range(0, 3) != 0);
      advMin = ($urandom_range(0, 7) == 0);
      clrSec = ($urandom_range(0, 31) == 0);
      rst    = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    tick = 1'b0;
    advMin = 1'b0;
    clrSec = 1'b0;
    rst = 1'b0;

    // Reset landing in the blank after digit 2 at 12:34
    doReset();
    run = 1'b1;
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (34) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1234", 32'(modelTime), 32'd754);
    found = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (digitSel == 2'd2 && seg == 7'h00) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("findBlank2", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstSeg", 32'(seg), 32'h3F);
    checkOutput("midRstSel", 32'(digitSel), 32'd0);
    checkOutput("midRstDp", 32'(dp), 32'd1);
    checkOutput("midRstTime", 32'(modelTime), 32'd0);
    repeat (FRAME) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
